dual_port_ram_asym: RTL and testbench

- Single-clock simple dual-port RAM with asymmetric port widths.
- The write port stores one RAM_DATA_WIDTH word per cycle.
- The read port returns RAM_RD2WR consecutive words, concatenated into one RAM_RD_WIDTH word, with registered output.
- Used as a width-converting buffer, e.g. byte writes gathered into 32-bit reads ahead of the DDR3 controller datapath.

---
 rtl/dual_port_ram_asym_if.sv | 24 ++
 rtl/dual_port_ram_asym.sv | 62 ++++++
 tb/tb_dual_port_ram_asym.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dual_port_ram_asym_if.sv
// rtl/dual_port_ram_asym_if.sv - write/read port bundle for the asymmetric dual-port RAM
interface dual_port_ram_asym_if #(
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_RD_WIDTH   = 32
);
  logic                      wr_port_ena;
  logic                      wr_en;
  logic [RAM_ADDR_WIDTH-1:0] wr_addr;
  logic [RAM_DATA_WIDTH-1:0] wr_data;
  logic                      rd_port_ena;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr;
  logic [RAM_RD_WIDTH-1:0]   rd_data;

  modport master (
    output wr_port_ena, wr_en, wr_addr, wr_data, rd_port_ena, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_port_ena, wr_en, wr_addr, wr_data, rd_port_ena, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/dual_port_ram_asym.sv
// rtl/dual_port_ram_asym.sv - narrow-write, wide-read simple dual-port RAM
// Optional DUAL_PORT_RAM_RST_CLR_EN: reset also clears every memory word.
module dual_port_ram_asym #(
  parameter int RAM_DEPTH      = 64,
  parameter int RAM_ADDR_WIDTH = 6,
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_RD_WIDTH   = 32,
  parameter int RAM_RD2WR      = 4
) (
  input logic                clk,
  input logic                rst_n,
  dual_port_ram_asym_if.slave bus
);

  logic [RAM_DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic [RAM_RD_WIDTH-1:0]   rd_data_d;
  logic [RAM_RD_WIDTH-1:0]   rd_data_q;

  logic wr_fire;
  assign wr_fire = bus.wr_port_ena && bus.wr_en;

`ifdef DUAL_PORT_RAM_RST_CLR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RAM_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end
`else
  // No reset branch on the array so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (rst_n && wr_fire) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end
`endif

  // Old memory contents are sampled here, giving read-first behaviour on overlap.
  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.rd_port_ena) begin
      for (int i = 0; i < RAM_RD2WR; i++) begin
        rd_data_d[i*RAM_DATA_WIDTH +: RAM_DATA_WIDTH] =
          mem_q[RAM_ADDR_WIDTH'((int'(bus.rd_addr) + i) % RAM_DEPTH)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_dual_port_ram_asym.sv
// tb/tb_dual_port_ram_asym.sv - scoreboard bench for dual_port_ram_asym
module tb_dual_port_ram_asym;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int RW    = 32;
  localparam int R2W   = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [DW-1:0] model [DEPTH];
  logic [RW-1:0] sb_q [$];

  dual_port_ram_asym_if #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .RAM_RD_WIDTH(RW)) bus ();

  dual_port_ram_asym #(
    .RAM_DEPTH(DEPTH), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW),
    .RAM_RD_WIDTH(RW), .RAM_RD2WR(R2W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] model_read(input logic [AW-1:0] a);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < R2W; i++) begin
      r[i*DW +: DW] = model[(int'(a) + i) % DEPTH];
    end
    return r;
  endfunction

  // One clock of stimulus; the expected read word is queued before the write lands (read-first).
  task automatic cyc(input logic wpe, input logic we, input logic [AW-1:0] wa,
                     input logic [DW-1:0] wd, input logic rpe, input logic [AW-1:0] ra,
                     input logic use_const, input logic [RW-1:0] const_val);
    bus.wr_port_ena = wpe;
    bus.wr_en       = we;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    bus.rd_port_ena = rpe;
    bus.rd_addr     = ra;
    if (rpe) sb_q.push_back(use_const ? const_val : model_read(ra));
    if (wpe && we) model[wa] = wd;
    @(negedge clk);
    bus.wr_port_ena = 1'b0;
    bus.wr_en       = 1'b0;
    bus.rd_port_ena = 1'b0;
  endtask

  task automatic rd_const(input logic [AW-1:0] ra, input logic [RW-1:0] exp);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, ra, 1'b1, exp);
  endtask

  // Monitor: any edge that accepted a read owes one word on the following negedge.
  initial begin
    logic fire;
    forever begin
      @(posedge clk);
      fire = bus.rd_port_ena && rst_n;
      @(negedge clk);
      if (fire) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=%h expected=none", bus.rd_data);
        end else begin
          chk("rd_data", bus.rd_data, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [RW-1:0] exp_after_rst;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.wr_port_ena = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.rd_port_ena = 1'b0;
    bus.rd_addr     = '0;

    repeat (2) @(negedge clk);
    chk("reset_rd_data", bus.rd_data, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < DEPTH; a++) begin
      cyc(1'b1, 1'b1, AW'(a), DW'(a), 1'b0, '0, 1'b0, '0);
    end

    rd_const(6'd0,  32'h03020100);
    rd_const(6'd4,  32'h07060504);
    rd_const(6'd16, 32'h13121110);

    cyc(1'b0, 1'b1, 6'd20, 8'hAA, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b0, 6'd20, 8'hAA, 1'b0, '0, 1'b0, '0);
    rd_const(6'd20, 32'h17161514);

    rd_const(6'd2, 32'h05040302);
    cyc(1'b1, 1'b1, 6'd62, 8'h3E, 1'b0, '0, 1'b0, '0);
    cyc(1'b1, 1'b1, 6'd63, 8'h3F, 1'b0, '0, 1'b0, '0);
    rd_const(6'd62, 32'h01003F3E);

    rd_const(6'd0, 32'h03020100);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 6'd8, 1'b0, '0);
    chk("hold", bus.rd_data, 32'h03020100);

    cyc(1'b1, 1'b1, 6'd5, 8'h55, 1'b1, 6'd4, 1'b1, 32'h07060504);
    rd_const(6'd4, 32'h07065504);

    // Reset dropped between edges, with an attempted write held across one edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", bus.rd_data, '0);
    bus.wr_port_ena = 1'b1;
    bus.wr_en       = 1'b1;
    bus.wr_addr     = 6'd0;
    bus.wr_data     = 8'hEE;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", bus.rd_data, '0);
    bus.wr_port_ena = 1'b0;
    bus.wr_en       = 1'b0;
    rst_n = 1'b1;
`ifdef DUAL_PORT_RAM_RST_CLR_EN
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    exp_after_rst = 32'h00000000;
`else
    exp_after_rst = 32'h03020100;
`endif
    @(negedge clk);
    rd_const(6'd0, exp_after_rst);

    for (int n = 0; n < 300; n++) begin
      cyc(1'($urandom), 1'($urandom), AW'($urandom_range(0, DEPTH-1)), DW'($urandom),
          1'($urandom), AW'($urandom_range(0, DEPTH-1)), 1'b0, '0);
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", RW'(sb_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
